// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with signed/unsigned handling and RISC-V special cases.
module rv32m_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             flush,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [2:0] {
        F_MUL    = 3'b000,
        F_MULH   = 3'b001,
        F_MULHSU = 3'b010,
        F_MULHU  = 3'b011,
        F_DIV    = 3'b100,
        F_DIVU   = 3'b101,
        F_REM    = 3'b110,
        F_REMU   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, next_state;
    muldiv_funct3_t     op;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] work;
    logic [CW-1:0]      count;
    logic               neg_res, neg_rem;

    logic               accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic               div_by_zero, overflow, special;
    logic [WIDTH-1:0]   abs_a, abs_b, special_val, final_val;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next, prod_fin;
    logic [WIDTH-1:0]   quo, rem;

    assign ready  = (state == IDLE) || (state == DONE);
    assign done   = (state == DONE);
    assign accept = start && ready && !flush;

    // Operand conditioning: magnitudes, result signs and special-case values.
    always_comb begin
        is_div      = op[2];
        a_signed    = (op == F_MULH) || (op == F_MULHSU) || (op == F_DIV) || (op == F_REM);
        b_signed    = (op == F_MULH) || (op == F_DIV) || (op == F_REM);
        a_neg       = a_signed && op_a[WIDTH-1];
        b_neg       = b_signed && op_b[WIDTH-1];
        abs_a       = a_neg ? ('0 - op_a) : op_a;
        abs_b       = b_neg ? ('0 - op_b) : op_b;
        div_by_zero = is_div && (op_b == '0);
        overflow    = ((op == F_DIV) || (op == F_REM)) && (op_a == MIN_NEG) && (op_b == '1);
        special     = div_by_zero || overflow;
        if (div_by_zero) begin
            special_val = op[1] ? op_a : '1;
        end else begin
            special_val = op[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration: multiply shifts the product right, divide shifts {rem, quo} left.
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? opnd : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, work[WIDTH-1:1]};
        div_shift = work[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
        end
        step_next = is_div ? div_next : mul_next;
        prod_fin  = neg_res ? ('0 - step_next) : step_next;
        quo       = step_next[WIDTH-1:0];
        rem       = step_next[2*WIDTH-1:WIDTH];
        case (op)
            F_MUL:                      final_val = prod_fin[WIDTH-1:0];
            F_MULH, F_MULHSU, F_MULHU:  final_val = prod_fin[2*WIDTH-1:WIDTH];
            F_DIV, F_DIVU:              final_val = neg_res ? ('0 - quo) : quo;
            F_REM, F_REMU:              final_val = neg_rem ? ('0 - rem) : rem;
            default:                    final_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Flush abandons PREP/CALC silently; it also masks a start offered in IDLE/DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = PREP;
            PREP: begin
                if (flush)        next_state = IDLE;
                else if (special) next_state = DONE;
                else              next_state = CALC;
            end
            CALC: begin
                if (flush)              next_state = IDLE;
                else if (count == '0)   next_state = DONE;
            end
            DONE: next_state = accept ? PREP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= F_MUL;
            op_a    <= '0;
            op_b    <= '0;
            opnd    <= '0;
            work    <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                op   <= muldiv_funct3_t'(funct3);
                op_a <= rs1_data;
                op_b <= rs2_data;
            end
            if (state == PREP && !flush) begin
                opnd    <= is_div ? abs_b : abs_a;
                work    <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                count   <= CW'(WIDTH - 1);
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                if (special) begin
                    result <= special_val;
                end
            end
            if (state == CALC && !flush) begin
                work  <= step_next;
                count <= count - CW'(1);
                if (count == '0) begin
                    result <= final_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit: directed vector table, hand-written
// back-to-back/flush/reset sequences and random ops against an arithmetic model.
module tb_rv32m_muldiv_unit;

    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    rv32m_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .ready    (ready),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions using 64-bit integers.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN_NEG;
            3:       return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    // Issues one op; returns the cycle (start cycle = 0) in which done was seen,
    // the result, and whether ready stayed low for every busy cycle.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] res, output bit ready_low);
        @(negedge clk);
        start    = 1'b1;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        @(negedge clk);
        start     = 1'b0;
        funct3    = 3'($urandom);
        rs1_data  = $urandom;
        rs2_data  = $urandom;
        lat       = 1;
        ready_low = 1'b1;
        while (!done && lat < 100) begin
            if (ready) ready_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    initial begin
        int          lat;
        int          cyc;
        int          done_seen;
        logic [31:0] res;
        logic [31:0] a, b;
        logic [2:0]  f3;
        bit          ready_low;
        bit          hold_ok;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd1, MIN_NEG,       MIN_NEG,       32'h4000_0000, 34};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         34};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         2};
        vecs[10] = '{3'd4, MIN_NEG,       32'hFFFF_FFFF, MIN_NEG,       2};
        vecs[11] = '{3'd6, MIN_NEG,       32'hFFFF_FFFF, 32'd0,         2};
        vecs[12] = '{3'd0, 32'd0,         32'hFFFF_FFFF, 32'd0,         34};
        vecs[13] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 2};
        vecs[14] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2};
        vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34};

        rst      = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = 3'd0;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready",  {31'b0, ready}, 32'd1);
        checkOutput("reset_done",   {31'b0, done},  32'd0);
        checkOutput("reset_result", result,         32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b, lat, res, ready_low);
            checkOutput($sformatf("vec%0d_result", i), res, vecs[i].exp);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_busy", i), {31'b0, ready_low}, 32'd1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
            checkOutput($sformatf("vec%0d_hold", i), result, vecs[i].exp);
        end

        // Back-to-back: second op started in the first op's DONE cycle, stray start at cycle 5.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd3; rs2_data = 32'd4;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("b2b_first_latency", 32'(cyc), 32'd34);
        checkOutput("b2b_first_result", result, 32'd12);
        start = 1'b1; funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd3;
        @(negedge clk);
        start = 1'b0;
        cyc     = 1;
        hold_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (result !== 32'd12) hold_ok = 1'b0;
            start = (cyc == 5);
            if (cyc == 5) begin
                funct3 = 3'd0; rs1_data = 32'd5; rs2_data = 32'd5;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("b2b_held_result", {31'b0, hold_ok}, 32'd1);
        checkOutput("b2b_second_latency", 32'(cyc), 32'd34);
        checkOutput("b2b_second_result", result, 32'd3);

        // Flush at cycle 10 of a divide.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1_data = 32'hFFFF_FFF9; rs2_data = 32'd2;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_ready", {31'b0, ready}, 32'd1);
        checkOutput("flush_result", result, 32'd3);
        done_seen = 0;
        repeat (40) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        checkOutput("flush_no_done", 32'(done_seen), 32'd0);
        checkOutput("flush_result_after", result, 32'd3);

        // Flush and start together: start must be dropped.
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1_data = 32'd8; rs2_data = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        checkOutput("flush_start_ready", {31'b0, ready}, 32'd1);
        @(negedge clk);
        checkOutput("flush_start_idle", {31'b0, ready}, 32'd1);

        // Asynchronous reset mid-CALC, between clock edges.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'h0000_FFFF; rs2_data = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("pre_reset_busy", {31'b0, ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_done",   {31'b0, done},  32'd0);
        checkOutput("async_reset_result", result,         32'd0);
        checkOutput("async_reset_ready",  {31'b0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3'd5, 32'd100, 32'd7, lat, res, ready_low);
        checkOutput("post_reset_result", res, 32'd14);
        checkOutput("post_reset_latency", 32'(lat), 32'd34);

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom);
            a  = pickOperand();
            b  = pickOperand();
            applyStimulus(f3, a, b, lat, res, ready_low);
            checkOutput($sformatf("rand%0d_f3_%0d_%08h_%08h", i, f3, a, b), res, refModel(f3, a, b));
            checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(refLatency(f3, a, b)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
